// File: rtl/uart_xmit_feeder.sv
// uart_xmit_feeder: host-side byte FIFO feeding the UART transmitter one request
// per byte, paced by xmit_doneH, with a watchdog on unacknowledged requests.
module uart_xmit_feeder #(
    parameter int DEPTH_LOG2  = 3,
    parameter int ACK_TIMEOUT = 7
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_l,
    input  logic                  wr_enaH,
    input  logic [7:0]            wr_dataH,
    input  logic                  flushH,
    output logic                  fullH,
    output logic [DEPTH_LOG2:0]   levelH,
    output logic                  wr_ovfH,
    output logic                  ack_errH,
    output logic                  idleH,
    output logic                  xmitH,
    output logic [7:0]            xmit_dataH,
    input  logic                  xmit_doneH
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int WD_W  = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] F_IDLE = 2'd0;
    localparam logic [1:0] F_REQ  = 2'd1;
    localparam logic [1:0] F_ACK  = 2'd2;
    localparam logic [1:0] F_BUSY = 2'd3;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [CW-1:0]         count;
    logic [1:0]            state;
    logic [WD_W-1:0]       wdCnt;
    logic                  doWrite;
    logic                  doPop;

    // Flush discards both a same-cycle write and a same-cycle pop.
    assign doWrite = wr_enaH && !fullH && !flushH;
    assign doPop   = (state == F_IDLE) && (count != '0) && xmit_doneH && !flushH;

    // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
    assign fullH  = count[DEPTH_LOG2];
    assign levelH = count;
    assign idleH  = (count == '0) && (state == F_IDLE) && xmit_doneH;

    // NOTE: storage has no reset; the pointers and count alone define validity,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge sys_clk) begin
        if (doWrite)
            mem[wrPtr] <= wr_dataH;
    end

    // NOTE: every sequential assignment is non-blocking so all registers update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            wr_ovfH <= 1'b0;
        end else begin
            wr_ovfH <= wr_enaH && fullH;
            if (flushH) begin
                rdPtr <= '0;
                wrPtr <= '0;
                count <= '0;
            end else begin
                if (doWrite)
                    wrPtr <= wrPtr + 1'b1;
                if (doPop)
                    rdPtr <= rdPtr + 1'b1;
                count <= count + CW'(doWrite) - CW'(doPop);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            state      <= F_IDLE;
            wdCnt      <= '0;
            xmitH      <= 1'b0;
            xmit_dataH <= 8'h00;
            ack_errH   <= 1'b0;
        end else begin
            xmitH <= 1'b0;
            case (state)
                F_IDLE: begin
                    if (doPop) begin
                        xmitH      <= 1'b1;
                        xmit_dataH <= mem[rdPtr];
                        state      <= F_REQ;
                    end
                end
                F_REQ: begin
                    wdCnt <= '0;
                    state <= F_ACK;
                end
                F_ACK: begin
                    // A transmitter that never leaves idle loses this byte.
                    if (!xmit_doneH) begin
                        state <= F_BUSY;
                    end else if (wdCnt == WD_W'(ACK_TIMEOUT - 1)) begin
                        ack_errH <= 1'b1;
                        state    <= F_IDLE;
                    end else begin
                        wdCnt <= wdCnt + 1'b1;
                    end
                end
                F_BUSY: begin
                    if (xmit_doneH)
                        state <= F_IDLE;
                end
                default: state <= F_IDLE;
            endcase
            if (flushH)
                ack_errH <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_xmit_feeder.sv
// Self-checking bench for uart_xmit_feeder: transmitter model plus a queue of
// expected request bytes compared whenever xmitH is seen.
module tb_uart_xmit_feeder;

    logic       sys_clk = 1'b0;
    logic       sys_rst_l = 1'b0;
    logic       wr_enaH = 1'b0;
    logic [7:0] wr_dataH = 8'h00;
    logic       flushH = 1'b0;
    logic       fullH;
    logic [3:0] levelH;
    logic       wr_ovfH;
    logic       ack_errH;
    logic       idleH;
    logic       xmitH;
    logic [7:0] xmit_dataH;
    logic       xmit_doneH = 1'b1;

    int checksRun = 0;
    int checksPassed = 0;

    logic [7:0] expQ[$];
    int  xmitCount = 0;
    int  pend = 0;
    int  busy = 0;
    int  busyCycles = 160;
    bit  txHold = 0;
    bit  stuck = 0;
    bit  prevXmit = 0;
    logic [7:0] inFlight = 8'h00;
    int  maxLevel = 0;
    int  snap;

    uart_xmit_feeder dut (
        .sys_clk    (sys_clk),
        .sys_rst_l  (sys_rst_l),
        .wr_enaH    (wr_enaH),
        .wr_dataH   (wr_dataH),
        .flushH     (flushH),
        .fullH      (fullH),
        .levelH     (levelH),
        .wr_ovfH    (wr_ovfH),
        .ack_errH   (ack_errH),
        .idleH      (idleH),
        .xmitH      (xmitH),
        .xmit_dataH (xmit_dataH),
        .xmit_doneH (xmit_doneH)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checksRun++;
        if (actual === expected)
            checksPassed++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    // Transmitter model: goes busy 2 cycles after a request unless stuck.
    always @(negedge sys_clk) begin
        if (xmitH) begin
            check("xmit_width", prevXmit, 0);
            check("xmit_expected", expQ.size() > 0, 1);
            if (expQ.size() > 0)
                check("xmit_data", xmit_dataH, expQ.pop_front());
            xmitCount++;
            inFlight = xmit_dataH;
            if (!stuck)
                pend = 2;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                busy = busyCycles;
                check("data_hold", xmit_dataH, inFlight);
            end
        end else if (busy > 0) begin
            busy--;
        end
        prevXmit = xmitH;
        if (int'(levelH) > maxLevel)
            maxLevel = int'(levelH);
        xmit_doneH = !(txHold || busy > 0);
    end

    task automatic cyc();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic writeByte(input logic [7:0] data, input bit expectTx);
        wr_enaH  = 1'b1;
        wr_dataH = data;
        if (expectTx)
            expQ.push_back(data);
        cyc();
        wr_enaH = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (expQ.size() == 0 && pend == 0 && busy == 0 && xmit_doneH && !xmitH) begin
                ok = 1;
                break;
            end
            cyc();
        end
        check({tag, "_drain"}, ok, 1);
        cyc();
        cyc();
    endtask

    task automatic waitDoneLow(input string tag);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (!xmit_doneH) begin
                ok = 1;
                break;
            end
            cyc();
        end
        check({tag, "_done_low"}, ok, 1);
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        check("rst_xmit", xmitH, 0);
        check("rst_data", xmit_dataH, 8'h00);
        check("rst_level", levelH, 0);
        check("rst_full", fullH, 0);
        check("rst_ovf", wr_ovfH, 0);
        check("rst_ackerr", ack_errH, 0);
        check("rst_idle", idleH, 1);
        sys_rst_l = 1'b1;
        cyc();
        cyc();

        // Single byte, request latency
        writeByte(8'hA5, 1);
        check("t1_level_after_write", levelH, 1);
        check("t1_no_xmit_yet", xmitH, 0);
        cyc();
        check("t1_xmit", xmitH, 1);
        check("t1_xmit_data", xmit_dataH, 8'hA5);
        check("t1_level_after_pop", levelH, 0);
        waitDrain("t1");
        check("t1_idle", idleH, 1);

        // Fill to full while the transmitter is busy, then overflow
        busyCycles = 20;
        txHold = 1;
        cyc();
        snap = xmitCount;
        for (int i = 1; i <= 9; i++) begin
            writeByte(8'(i), i <= 8);
            if (i == 7)
                check("t2_not_full_7", fullH, 0);
            if (i == 8) begin
                check("t2_full_8", fullH, 1);
                check("t2_level_8", levelH, 8);
                check("t2_no_ovf_8", wr_ovfH, 0);
            end
            if (i == 9) begin
                check("t2_ovf_9", wr_ovfH, 1);
                check("t2_level_9", levelH, 8);
            end
        end
        cyc();
        check("t2_ovf_pulse_end", wr_ovfH, 0);
        txHold = 0;
        waitDrain("t2");
        check("t2_xmit_count", xmitCount - snap, 8);
        check("t2_level_empty", levelH, 0);

        // Wrap and simultaneous write+pop
        busyCycles = 3;
        maxLevel = 0;
        writeByte(8'h30, 1);
        check("t3_level_first", levelH, 1);
        writeByte(8'h31, 1);
        check("t3_level_wr_pop", levelH, 1);
        check("t3_xmit_wr_pop", xmitH, 1);
        for (int i = 2; i < 10; i++) begin
            writeByte(8'h30 + 8'(i), 1);
            cyc();
        end
        waitDrain("t3");
        check("t3_level_bound", maxLevel <= 8, 1);
        check("t3_level_empty", levelH, 0);

        // Request never acknowledged
        stuck = 1;
        writeByte(8'h41, 1);
        writeByte(8'h42, 1);
        check("t4_req", xmitH, 1);
        repeat (7) cyc();
        check("t4_ackerr_before", ack_errH, 0);
        cyc();
        check("t4_ackerr_set", ack_errH, 1);
        cyc();
        check("t4_next_req", xmitH, 1);
        waitDrain("t4");
        repeat (10) cyc();
        check("t4_ackerr_sticky", ack_errH, 1);
        check("t4_idle", idleH, 1);
        stuck = 0;

        // Flush with bytes queued and one in flight
        busyCycles = 40;
        writeByte(8'h50, 1);
        for (int i = 1; i <= 5; i++)
            writeByte(8'h50 + 8'(i), 0);
        waitDoneLow("t5");
        cyc();
        check("t5_level_queued", levelH, 5);
        snap = xmitCount;
        flushH = 1'b1;
        cyc();
        flushH = 1'b0;
        check("t5_level_flushed", levelH, 0);
        check("t5_full_flushed", fullH, 0);
        check("t5_ackerr_cleared", ack_errH, 0);
        check("t5_in_flight", xmit_doneH, 0);
        waitDrain("t5");
        repeat (5) cyc();
        check("t5_no_more_xmit", xmitCount - snap, 0);
        check("t5_idle", idleH, 1);

        // Reset in F_BUSY
        busyCycles = 30;
        writeByte(8'h60, 1);
        writeByte(8'h61, 0);
        writeByte(8'h62, 0);
        waitDoneLow("t6");
        cyc();
        cyc();
        sys_rst_l = 1'b0;
        #1;
        check("t6_rst_xmit", xmitH, 0);
        check("t6_rst_data", xmit_dataH, 8'h00);
        check("t6_rst_level", levelH, 0);
        check("t6_rst_full", fullH, 0);
        check("t6_rst_ovf", wr_ovfH, 0);
        check("t6_rst_ackerr", ack_errH, 0);
        cyc();
        sys_rst_l = 1'b1;
        snap = xmitCount;
        cyc();
        check("t6_not_idle_while_busy", idleH, 0);
        waitDrain("t6");
        repeat (5) cyc();
        check("t6_no_req_after_rst", xmitCount - snap, 0);
        writeByte(8'h6A, 1);
        waitDrain("t6b");
        check("t6_new_req", xmitCount - snap, 1);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
